// File: rtl/dcache_pkg.sv
// Shared constants, FSM encoding, request payload and address helpers for the data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TAG_LEN = 23;
    localparam int unsigned IDX_LEN = 5;
    localparam int unsigned TAG_NUM = 32;
    localparam int unsigned LINE_W  = 128;
    localparam int unsigned WORDS   = LINE_W / WORD_W;
    localparam int unsigned STRB_W  = LINE_W / 8;
    localparam int unsigned WSTRB_W = WORD_W / 8;

    // Address field positions: tag addr[31:9], index addr[8:4], word select addr[3:2]
    localparam int unsigned OFF_LO = 2;
    localparam int unsigned OFF_HI = 3;
    localparam int unsigned IDX_LO = 4;
    localparam int unsigned IDX_HI = 8;
    localparam int unsigned TAG_LO = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic               we;
        logic [WORD_W-1:0]  wdata;
        logic [WSTRB_W-1:0] wstrb;
    } req_t;

    // Line-aligned bus address from a stored tag and an index
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_LEN-1:0] tag,
                                                    input logic [IDX_LEN-1:0] idx);
        return {tag, idx, 4'b0000};
    endfunction

    // 32-bit word at word offset 'off' within a line
    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [1:0] off);
        return line[{off, 5'd0} +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// LSU and memory-bus signals of the data cache; slave = controller view, master = environment view.
interface dcache_if;
    import dcache_pkg::*;

    logic                req_valid_i;
    logic                req_ready_o;
    logic [ADDR_W-1:0]   req_addr_i;
    logic                req_we_i;
    logic [WORD_W-1:0]   req_wdata_i;
    logic [WSTRB_W-1:0]  req_wstrb_i;
    logic                resp_valid_o;
    logic                resp_ready_i;
    logic [WORD_W-1:0]   resp_rdata_o;
    logic                mem_req_valid_o;
    logic                mem_req_ready_i;
    logic                mem_req_we_o;
    logic [ADDR_W-1:0]   mem_req_addr_o;
    logic [LINE_W-1:0]   mem_wdata_o;
    logic                mem_resp_valid_i;
    logic [LINE_W-1:0]   mem_rdata_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_wstrb_i,
        input  resp_ready_i, mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o,
        output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_wstrb_i,
        output resp_ready_i, mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o,
        input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dcache_data_array.sv
// Line storage: combinational read by index, one byte-enabled write port.
module dcache_data_array
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic [IDX_LEN-1:0] raddr,
    output logic [LINE_W-1:0]  rdata_c,
    input  logic               we,
    input  logic [IDX_LEN-1:0] waddr,
    input  logic [LINE_W-1:0]  wdata,
    input  logic [STRB_W-1:0]  wbe
);

    logic [LINE_W-1:0] lines [TAG_NUM];

    assign rdata_c = lines[raddr];

    // Byte-masked line write; contents are only meaningful once the tag store marks a line valid
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wbe[b]) begin
                    lines[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped data-cache controller: lookup, dirty writeback, line fill, re-lookup.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    dcache_if.slave bus
);

    state_t             state_q, state_d;
    req_t               req_q;
    logic [TAG_LEN-1:0] tag_q [TAG_NUM];
    logic [TAG_NUM-1:0] valid_q, dirty_q;

    logic               resp_valid_q;
    logic [WORD_W-1:0]  resp_rdata_q;
    logic               mem_req_valid_q, mem_req_we_q;
    logic [ADDR_W-1:0]  mem_req_addr_q;
    logic [LINE_W-1:0]  mem_wdata_q;

    logic [IDX_LEN-1:0] idx;
    logic [TAG_LEN-1:0] req_tag;
    logic [1:0]         off;
    logic               hit_c;
    logic [LINE_W-1:0]  line_c;
    logic               arr_we;
    logic [LINE_W-1:0]  arr_wdata;
    logic [STRB_W-1:0]  arr_wbe;
    logic               unused_addr_bits;

    assign idx              = req_q.addr[IDX_HI:IDX_LO];
    assign req_tag          = req_q.addr[ADDR_W-1:TAG_LO];
    assign off              = req_q.addr[OFF_HI:OFF_LO];
    assign hit_c            = valid_q[idx] && (tag_q[idx] == req_tag);
    assign unused_addr_bits = ^req_q.addr[OFF_LO-1:0];

    assign bus.req_ready_o     = (state_q == IDLE);
    assign bus.resp_valid_o    = resp_valid_q;
    assign bus.resp_rdata_o    = resp_rdata_q;
    assign bus.mem_req_valid_o = mem_req_valid_q;
    assign bus.mem_req_we_o    = mem_req_we_q;
    assign bus.mem_req_addr_o  = mem_req_addr_q;
    assign bus.mem_wdata_o     = mem_wdata_q;

    dcache_data_array u_data (
        .clk     (clk),
        .raddr   (idx),
        .rdata_c (line_c),
        .we      (arr_we),
        .waddr   (idx),
        .wdata   (arr_wdata),
        .wbe     (arr_wbe)
    );

    // Next-state and data-array write control
    always_comb begin
        state_d   = state_q;
        arr_we    = 1'b0;
        arr_wdata = {WORDS{req_q.wdata}};
        arr_wbe   = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit_c) begin
                    state_d = RESP;
                    if (req_q.we) begin
                        arr_we  = 1'b1;
                        arr_wbe = STRB_W'(req_q.wstrb) << {off, 2'b00};
                    end
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_d = WB_REQ;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            WB_REQ: begin
                if (bus.mem_req_ready_i) state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (bus.mem_resp_valid_i) state_d = FILL_REQ;
            end
            FILL_REQ: begin
                if (bus.mem_req_ready_i) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    state_d   = LOOKUP;
                    arr_we    = 1'b1;
                    arr_wdata = bus.mem_rdata_i;
                    arr_wbe   = '1;
                end
            end
            RESP: begin
                if (bus.resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, tag store, latched request and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            req_q           <= '0;
            valid_q         <= '0;
            dirty_q         <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_wdata_q     <= '0;
            for (int i = 0; i < int'(TAG_NUM); i++) tag_q[i] <= '0;
        end else begin
            state_q         <= state_d;
            resp_valid_q    <= (state_d == RESP);
            mem_req_valid_q <= (state_d == WB_REQ) || (state_d == FILL_REQ);

            if (state_q == IDLE && bus.req_valid_i) begin
                req_q <= '{addr: bus.req_addr_i, we: bus.req_we_i,
                           wdata: bus.req_wdata_i, wstrb: bus.req_wstrb_i};
            end

            if (state_q == LOOKUP && hit_c) begin
                resp_rdata_q <= req_q.we ? '0 : word_sel(line_c, off);
                if (req_q.we) dirty_q[idx] <= 1'b1;
            end

            // Bus request fields are loaded once on entry and held until the handshake
            if (state_q == LOOKUP && state_d == WB_REQ) begin
                mem_req_we_q   <= 1'b1;
                mem_req_addr_q <= line_addr(tag_q[idx], idx);
                mem_wdata_q    <= line_c;
            end
            if (state_q != FILL_REQ && state_d == FILL_REQ) begin
                mem_req_we_q   <= 1'b0;
                mem_req_addr_q <= line_addr(req_tag, idx);
            end

            if (state_q == WB_WAIT && bus.mem_resp_valid_i) dirty_q[idx] <= 1'b0;

            if (state_q == FILL_WAIT && bus.mem_resp_valid_i) begin
                tag_q[idx]   <= req_tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed requests, zero-wait memory model, decoupled monitors.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam logic [127:0] L1 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [127:0] L2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] L3 = 128'h13579BDF_2468ACE0_CAFEF00D_0BADC0DE;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_resp_t;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } exp_mem_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_if bus ();

    dcache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_resp_t exp_resp[$];
    exp_mem_t  exp_mem[$];
    int        vectors = 0;
    int        miscompares = 0;
    bit        mem_hold = 1'b0;

    int           ncyc = 0;
    int           t0 = 0;
    bit           rseen = 1'b0;
    logic [31:0]  rprev;
    bit           mseen = 1'b0;
    logic [32:0]  mprev_hdr;
    logic [127:0] mprev_wdata;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        case (a)
            32'h8000_0010: return L1;
            32'h8000_0210: return L2;
            32'h8000_0020: return L3;
            default:       return {4{a}};
        endcase
    endfunction

    // Memory model: response pulse in the cycle after each accepted request
    initial begin
        logic        hs_we;
        logic [31:0] hs_addr;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_rdata_i      = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_req_valid_o && bus.mem_req_ready_i && !mem_hold) begin
                hs_we   = bus.mem_req_we_o;
                hs_addr = bus.mem_req_addr_o;
                @(posedge clk);
                #1;
                bus.mem_resp_valid_i = 1'b1;
                bus.mem_rdata_i      = hs_we ? '0 : mem_line(hs_addr);
                @(posedge clk);
                #1;
                bus.mem_resp_valid_i = 1'b0;
                bus.mem_rdata_i      = '0;
            end
        end
    end

    // Response monitor: latency to first valid, hold while stalled, data at handshake
    initial begin
        exp_resp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                rseen = 1'b0;
            end else begin
                if (bus.req_valid_i && bus.req_ready_o) t0 = ncyc;
                if (bus.resp_valid_o) begin
                    if (exp_resp.size() == 0) begin
                        flag("unexpected_resp");
                    end else if (!rseen) begin
                        check("resp_latency", 128'(ncyc - t0), 128'(exp_resp[0].lat));
                        rseen = 1'b1;
                        rprev = bus.resp_rdata_o;
                    end else begin
                        check("resp_hold", 128'(bus.resp_rdata_o), 128'(rprev));
                    end
                    if (bus.resp_ready_i && exp_resp.size() != 0) begin
                        e = exp_resp.pop_front();
                        check("resp_rdata", 128'(bus.resp_rdata_o), 128'(e.rdata));
                        rseen = 1'b0;
                    end
                end
            end
        end
    end

    // Bus request monitor: held stable until accepted, one expected entry per handshake
    initial begin
        exp_mem_t m;
        forever begin
            @(negedge clk);
            if (rst) begin
                mseen = 1'b0;
            end else if (bus.mem_req_valid_o) begin
                if (mseen) begin
                    check("mem_req_hold_hdr", 128'({bus.mem_req_we_o, bus.mem_req_addr_o}), 128'(mprev_hdr));
                    check("mem_req_hold_wdata", bus.mem_wdata_o, mprev_wdata);
                end else begin
                    mseen       = 1'b1;
                    mprev_hdr   = {bus.mem_req_we_o, bus.mem_req_addr_o};
                    mprev_wdata = bus.mem_wdata_o;
                end
                if (bus.mem_req_ready_i) begin
                    mseen = 1'b0;
                    if (exp_mem.size() == 0) begin
                        flag("unexpected_mem_req");
                    end else begin
                        m = exp_mem.pop_front();
                        check("mem_req_we", 128'(bus.mem_req_we_o), 128'(m.we));
                        check("mem_req_addr", 128'(bus.mem_req_addr_o), 128'(m.addr));
                        if (m.we) check("mem_wdata", bus.mem_wdata_o, m.wdata);
                    end
                end
            end else if (mseen) begin
                mseen = 1'b0;
                flag("mem_req_dropped");
            end
        end
    end

    task automatic expect_mem(input logic we, input logic [31:0] a, input logic [127:0] wd);
        exp_mem.push_back('{we, a, wd});
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] exp_rd, input int lat);
        bit accepted = 1'b0;
        exp_resp.push_back('{exp_rd, lat});
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_we_i    = we;
        bus.req_wdata_i = wd;
        bus.req_wstrb_i = ws;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) flag("req_accept_timeout");
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_resp.size() == 0 && exp_mem.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            flag("transaction_timeout");
            exp_resp.delete();
            exp_mem.delete();
        end
    endtask

    task automatic wait_neg(input string name, input bit use_resp);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (use_resp ? bus.resp_valid_o : bus.mem_req_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag(name);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.req_valid_i     = 1'b0;
        bus.req_addr_i      = '0;
        bus.req_we_i        = 1'b0;
        bus.req_wdata_i     = '0;
        bus.req_wstrb_i     = '0;
        bus.resp_ready_i    = 1'b1;
        bus.mem_req_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 128'(bus.req_ready_o), 128'(1));
        check("rst_resp_valid", 128'(bus.resp_valid_o), 128'(0));
        check("rst_resp_rdata", 128'(bus.resp_rdata_o), 128'(0));
        check("rst_mem_valid", 128'(bus.mem_req_valid_o), 128'(0));
        check("rst_mem_hdr", 128'({bus.mem_req_we_o, bus.mem_req_addr_o}), 128'(0));
        check("rst_mem_wdata", bus.mem_wdata_o, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold load: clean miss, single fill
        expect_mem(1'b0, 32'h8000_0010, '0);
        issue(32'h8000_0010, 1'b0, '0, 4'h0, 32'h3322_1100, 5);
        wait_done();
        // Hit on word 1
        issue(32'h8000_0014, 1'b0, '0, 4'h0, 32'h7766_5544, 2);
        wait_done();
        // Partial store, then read back the merged word
        issue(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2);
        wait_done();
        issue(32'h8000_0010, 1'b0, '0, 4'h0, 32'h3322_BEEF, 2);
        wait_done();
        // Conflict miss on a dirty line: writeback of merged line, then fill
        expect_mem(1'b1, 32'h8000_0010, 128'hFFEEDDCC_BBAA9988_77665544_3322BEEF);
        expect_mem(1'b0, 32'h8000_0210, '0);
        issue(32'h8000_0210, 1'b0, '0, 4'h0, 32'h0302_0100, 7);
        wait_done();
        issue(32'h8000_021C, 1'b0, '0, 4'h0, 32'h0F0E_0D0C, 2);
        wait_done();

        // Bus ready low for 5 cycles, response ready low for 3
        @(posedge clk);
        #1;
        bus.mem_req_ready_i = 1'b0;
        bus.resp_ready_i    = 1'b0;
        expect_mem(1'b0, 32'h8000_0020, '0);
        issue(32'h8000_0028, 1'b0, '0, 4'h0, 32'h2468_ACE0, 10);
        wait_neg("mem_req_timeout", 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        bus.mem_req_ready_i = 1'b1;
        wait_neg("resp_timeout", 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        bus.resp_ready_i = 1'b1;
        wait_done();
        issue(32'h8000_002C, 1'b0, '0, 4'h0, 32'h1357_9BDF, 2);
        wait_done();

        // Dirty the index-1 line, then reset while its writeback awaits completion
        issue(32'h8000_0210, 1'b1, 32'h1122_3344, 4'b1111, 32'h0, 2);
        wait_done();
        mem_hold = 1'b1;
        expect_mem(1'b1, 32'h8000_0210, 128'h0F0E0D0C_0B0A0908_07060504_11223344);
        issue(32'h8000_0410, 1'b0, '0, 4'h0, 32'h0, 7);
        for (int i = 0; i < 50 && exp_mem.size() != 0; i++) @(negedge clk);
        if (exp_mem.size() != 0) begin
            flag("wb_req_timeout");
            exp_mem.delete();
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_resp.delete();
        @(posedge clk);
        @(negedge clk);
        check("wbrst_req_ready", 128'(bus.req_ready_o), 128'(1));
        check("wbrst_mem_valid", 128'(bus.mem_req_valid_o), 128'(0));
        check("wbrst_resp_valid", 128'(bus.resp_valid_o), 128'(0));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_hold = 1'b0;
        // All lines invalid again: this load must miss and refill
        expect_mem(1'b0, 32'h8000_0010, '0);
        issue(32'h8000_0010, 1'b0, '0, 4'h0, 32'h3322_1100, 5);
        wait_done();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped data-cache controller between the LSU and the memory bus. It accepts one 32-bit load/store at a time and looks up a 32-entry tag/valid/dirty store. Hits are served from a 128-bit-per-line data array. Misses are sequenced through an optional dirty-victim writeback, then a line fill and a re-lookup. Only one request is outstanding; the LSU stalls on `req_ready_o`.

## Interface
- `TAG_LEN`, 23: tag width, addr[31:9]
- `IDX_LEN`, 5: index width, addr[8:4]
- `TAG_NUM`, 32: number of lines (2^IDX_LEN)
- `LINE_W`, 128: line width in bits (offset addr[3:0], word select addr[3:2])
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `req_valid_i` in 1: LSU request valid
- `req_ready_o` out 1: controller can accept a request (IDLE only)
- `req_addr_i` in 32: byte address, word-aligned
- `req_we_i` in 1: 1 = store, 0 = load
- `req_wdata_i` in 32: store data
- `req_wstrb_i` in 4: store byte enables
- `resp_valid_o` out 1: response valid
- `resp_ready_i` in 1: LSU accepts response
- `resp_rdata_o` out 32: load data (0 for stores)
- `mem_req_valid_o` out 1: bus request valid
- `mem_req_ready_i` in 1: bus accepts request
- `mem_req_we_o` out 1: 1 = line writeback, 0 = line fill
- `mem_req_addr_o` out 32: line-aligned address, [3:0] = 0
- `mem_wdata_o` out 128: victim line
- `mem_resp_valid_i` in 1: one-cycle pulse; write done or fill data valid
- `mem_rdata_i` in 128: fill data

## Operation
- State: `tag[TAG_NUM]`, `valid[TAG_NUM]`, `dirty[TAG_NUM]`, plus latched request fields `addr_q`, `we_q`, `wdata_q`, `wstrb_q`.
- FSM states: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`, latch the request fields and go to LOOKUP.
- LOOKUP: hit = `valid[idx] && tag[idx]==addr_q[31:9]`.
  - Hit, load: capture the word at offset `addr_q[3:2]` into `resp_rdata_o`, then go to RESP.
  - Hit, store: merge `wdata_q` into the line per `wstrb_q`, set `dirty[idx]`=1, then go to RESP.
  - Miss with `valid&&dirty`: go to WB_REQ.
  - Otherwise: go to FILL_REQ.
- WB_REQ: `mem_req_valid_o`=1, `we`=1, addr = {tag[idx], idx, 4'b0}, wdata = line. On `mem_req_ready_i`, go to WB_WAIT.
- WB_WAIT: on `mem_resp_valid_i`, clear `dirty[idx]` and go to FILL_REQ.
- FILL_REQ: `mem_req_valid_o`=1, `we`=0, addr = {addr_q[31:4], 4'b0}. On ready, go to FILL_WAIT.
- FILL_WAIT: on `mem_resp_valid_i`, write `mem_rdata_i` to the line, `tag[idx]`=addr_q tag, `valid`=1, `dirty`=0, then go to LOOKUP. The re-lookup always hits.
- RESP: `resp_valid_o`=1, held stable until `resp_ready_i`, then go to IDLE.
- `mem_req_*` outputs are held stable while valid and not ready. Valid never drops before the handshake.
- `mem_resp_valid_i` outside WB_WAIT/FILL_WAIT is ignored.
- Reset values:
  - FSM = IDLE; all `valid`/`dirty` = 0; tags = 0.
  - `req_ready_o`=1 (held in IDLE, as defined above).
  - `resp_valid_o`=0, `resp_rdata_o`=0.
  - `mem_req_valid_o`=0, `mem_req_we_o`=0, `mem_req_addr_o`=0, `mem_wdata_o`=0.
- Reset mid-operation discards the in-flight request and any dirty data. The bus owner must also be reset.

## Timing
- Request accepted at edge N. LOOKUP occupies cycle N+1.
- Hit: `resp_valid_o` is high from cycle N+2. A back-to-back request can be accepted at the edge after the response handshake.
- Clean miss: 1 (LOOKUP) + fill handshake + fill wait + 1 (re-LOOKUP) + RESP. With zero-wait memory (ready at first cycle, resp the next), `resp_valid_o` rises at cycle N+5.
- Dirty miss with zero-wait memory: +2 cycles, so N+7.
- Data-array and tag writes take effect at the edge leaving LOOKUP/FILL_WAIT. The next lookup sees them.
- `req_ready_o` is combinational from state (IDLE only), with no dependence on `req_valid_i`.

## Structure
- Shared package `dcache_pkg`:
  - constants TAG_LEN/IDX_LEN/LINE_W and offset field positions;
  - FSM state enum;
  - helper functions `line_addr(tag, idx)` and `word_sel(line, off)`.
- Sub-module `dcache_data_array`:
  - TAG_NUM × LINE_W registers;
  - combinational read by index;
  - single write port with 16-bit byte-enable.
- Tag/valid/dirty stay in `dcache_ctrl`, because the controller needs the stored tag for writeback addresses.

## Test plan
- Cold load, addr 0x8000_0010, zero-wait memory returning line 0x44..._33_22_11_00 (words 0x33221100 at offset 0) -> exactly one fill request at 0x8000_0010, `we`=0; `resp_rdata_o`=word 0 at N+5.
- Repeat load 0x8000_0014 -> hit, no `mem_req_valid_o`; `resp_valid_o` at N+2 with word 1.
- Store 0xDEADBEEF, wstrb 4'b0011, to 0x8000_0010, then load -> read returns upper half unchanged and lower half 0xBEEF; `dirty[1]`=1.
- Load 0x8000_0210 (same index, new tag) -> writeback to 0x8000_0010 with the merged line, then fill at 0x8000_0210; response at N+7.
- `mem_req_ready_i` held low for 5 cycles, and `resp_ready_i` low for 3 -> `mem_req_*` and `resp_*` stay stable; no duplicate requests.
- `rst` asserted in WB_WAIT -> next cycle IDLE, `mem_req_valid_o`=0, `req_ready_o`=1, and a subsequent load to 0x8000_0010 misses.
